// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
// Multiplexes one BCD-to-7-segment decoder across NUM_DIGITS common-anode
// digits. The BCD word is snapshotted once per frame. Each digit slot has a
// blanking guard followed by a fixed dwell with the anode driven low. All
// outputs come from flops, so no input reaches an output combinationally.
module seg7_scan_controller #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 12500,
    parameter int unsigned BLANK_CYCLES = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    lz_en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              bcd_out,
    output logic                    bp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    snap_lz_q, snap_lz_d;

    logic [3:0]              bcd_out_q, bcd_out_d;
    logic                    bp_out_q, bp_out_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run;
    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic                    cur_supp;
    logic                    last_dwell;

    // Leading-zero mask: walk down from the top digit while digit and point stay zero
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (snap_digits_q[4*i +: 4] == 4'd0) & ~snap_dp_q[i];
            supp[i]  = snap_lz_q & zero_run;
        end
    end

    // Select the snapshot fields belonging to the digit currently being scanned
    always_comb begin
        cur_bcd  = '0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_bcd  = snap_digits_q[4*i +: 4];
                cur_dp   = snap_dp_q[i];
                cur_supp = supp[i];
            end
        end
    end

    assign last_dwell = (state_q == ST_DRIVE) && (cnt_q == DWELL_LAST) && (idx_q == IDX_LAST);

    // Next-state logic: scan sequencing, slot timing and snapshot capture
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_lz_d     = snap_lz_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) begin
                    snap_digits_d = digits_in;
                    snap_dp_d     = dp_in;
                    snap_lz_d     = lz_en;
                    state_d       = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                // A completed frame wins over a same-cycle enable drop
                if (last_dwell) begin
                    cnt_d         = '0;
                    idx_d         = '0;
                    snap_digits_d = digits_in;
                    snap_dp_d     = dp_in;
                    snap_lz_d     = lz_en;
                    state_d       = enable ? ST_BLANK : ST_IDLE;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Output decode; outputs trail the state by one cycle except that
    // dropping enable blanks the anodes on the very next edge
    always_comb begin
        bcd_out_d    = cur_bcd;
        bp_out_d     = cur_dp;
        digit_sel_d  = '1;
        frame_done_d = last_dwell;
        if (enable && (state_q == ST_DRIVE) && !cur_supp) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    digit_sel_d[i] = 1'b0;
                end
            end
        end
    end

    // Sequencer and snapshot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_lz_q     <= snap_lz_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out_q    <= '0;
            bp_out_q     <= 1'b0;
            digit_sel_q  <= '1;
            frame_done_q <= 1'b0;
        end else begin
            bcd_out_q    <= bcd_out_d;
            bp_out_q     <= bp_out_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd_out    = bcd_out_q;
    assign bp_out     = bp_out_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller (4 digits, dwell 8, blank 2).
// Expected digit slots are queued when stimulus is applied and consumed
// cycle by cycle as the DUT scans.
module tb_seg7_scan_controller;

    localparam int unsigned N     = 4;
    localparam int unsigned DWELL = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned SLOT  = DWELL + BLANK;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] bcd;
        logic       bp;
    } slot_t;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         lz_en;
    logic [15:0]  digits_in;
    logic [3:0]   dp_in;
    logic [3:0]   bcd_out;
    logic         bp_out;
    logic [3:0]   digit_sel;
    logic         frame_done;

    int unsigned  n_checks;
    int unsigned  n_errors;
    slot_t        exp_q[$];

    seg7_scan_controller #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .lz_en     (lz_en),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .bcd_out   (bcd_out),
        .bp_out    (bp_out),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic slot_t expect_slot(input logic [15:0] d, input logic [3:0] dp,
                                          input logic lz, input int i);
        slot_t      s;
        logic [3:0] one;
        logic       hidden;
        one    = 4'b0001;
        s.bcd  = 4'((d >> (4 * i)) & 16'h000F);
        s.bp   = dp[i];
        hidden = lz && (i > 0) && ((d >> (4 * i)) == 16'd0) && ((dp >> i) == 4'd0);
        s.sel  = hidden ? 4'b1111 : ~(one << i);
        return s;
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        for (int i = 0; i < int'(N); i++) exp_q.push_back(expect_slot(d, dp, lz, i));
    endtask

    // Stop scanning, load new inputs, restart; returns just after edge k
    task automatic start_scan(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        digits_in = d;
        dp_in     = dp;
        lz_en     = lz;
        enable    = 1'b1;
        push_frame(d, dp, lz);
        @(posedge clk);
    endtask

    // Consume n slots from the scoreboard, checking every cycle of each slot
    task automatic run_slots(input int n, input int first_slot);
        slot_t e;
        int    sidx;
        for (int s = 0; s < n; s++) begin
            sidx = (first_slot + s) % int'(N);
            if (exp_q.size() == 0) begin
                check_val("queue_empty", 32'd1, 32'd0);
                return;
            end
            e = exp_q.pop_front();
            for (int c = 0; c < int'(SLOT); c++) begin
                @(posedge clk);
                #1;
                check_val($sformatf("sel_s%0d_c%0d", sidx, c), 32'(digit_sel),
                          (c < int'(BLANK)) ? 32'hF : 32'(e.sel));
                check_val($sformatf("bcd_s%0d_c%0d", sidx, c), 32'(bcd_out), 32'(e.bcd));
                check_val($sformatf("bp_s%0d_c%0d", sidx, c), 32'(bp_out), 32'(e.bp));
                check_val($sformatf("fdone_s%0d_c%0d", sidx, c), 32'(frame_done),
                          32'((sidx == int'(N) - 1) && (c == int'(SLOT) - 1)));
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        lz_en     = 1'b0;
        digits_in = 16'h1234;
        dp_in     = 4'b0000;

        // Reset state with enable held high
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_sel", 32'(digit_sel), 32'hF);
        check_val("rst_bcd", 32'(bcd_out), 32'h0);
        check_val("rst_bp", 32'(bp_out), 32'h0);
        check_val("rst_fdone", 32'(frame_done), 32'h0);

        // Release: edge k is the next posedge, then two full frames of 1234
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h1234, 4'b0000, 1'b0);
        push_frame(16'h1234, 4'b0000, 1'b0);
        @(posedge clk);
        run_slots(8, 0);

        // Leading-zero suppression and pass-through patterns
        start_scan(16'h0057, 4'b0000, 1'b1);
        run_slots(4, 0);
        start_scan(16'h0000, 4'b0000, 1'b1);
        run_slots(4, 0);
        start_scan(16'h0057, 4'b0100, 1'b1);
        run_slots(4, 0);
        start_scan(16'h0000, 4'b0000, 1'b0);
        run_slots(4, 0);
        start_scan(16'hCAFE, 4'b1010, 1'b1);
        run_slots(4, 0);

        // Mid-frame input change is held off until the next snapshot
        start_scan(16'h1234, 4'b0000, 1'b0);
        push_frame(16'h9876, 4'b0000, 1'b0);
        fork
            run_slots(8, 0);
            begin
                repeat (14) @(posedge clk);
                @(negedge clk);
                digits_in = 16'h9876;
            end
        join

        // Drop enable during digit 2 dwell
        start_scan(16'h1234, 4'b0001, 1'b0);
        run_slots(2, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("d2_dwell_sel", 32'(digit_sel), 32'hB);
        @(negedge clk);
        enable = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("off_sel_c%0d", c), 32'(digit_sel), 32'hF);
            check_val($sformatf("off_fdone_c%0d", c), 32'(frame_done), 32'h0);
        end
        exp_q.delete();
        @(negedge clk);
        enable = 1'b1;
        push_frame(16'h1234, 4'b0001, 1'b0);
        @(posedge clk);
        run_slots(1, 0);
        exp_q.delete();

        // Asynchronous reset mid-dwell clears anodes before the next edge
        start_scan(16'h4321, 4'b0000, 1'b0);
        run_slots(1, 0);
        repeat (4) @(posedge clk);
        #1;
        check_val("pre_rst_sel", 32'(digit_sel), 32'hD);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_sel", 32'(digit_sel), 32'hF);
        check_val("async_rst_bcd", 32'(bcd_out), 32'h0);
        check_val("async_rst_fdone", 32'(frame_done), 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h4321, 4'b0000, 1'b0);
        @(posedge clk);
        run_slots(2, 0);
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
